// File: rtl/reflet_regbank_pkg.sv
// Shared definitions for the Reflet register bank.
//   - Special register indices (WR, SR, SP, PC). They are all below 8, so they
//     are valid for every supported NUM_REGS.
//   - Reset values, stored 64 bits wide and truncated to WORDSIZE where used.
//   - SP operation codes.
//   - reset_value(): returns the reset word for a given register index.
package reflet_regbank_pkg;

    localparam int WR_ID = 0;
    localparam int SR_ID = 1;
    localparam int SP_ID = 6;
    localparam int PC_ID = 7;

    localparam logic [63:0] WR_RESET = 64'h0;
    localparam logic [63:0] SR_RESET = 64'h0;
    localparam logic [63:0] SP_RESET = 64'h0;
    localparam logic [63:0] PC_RESET = 64'h0;
    localparam logic [63:0] GP_RESET = 64'h0;

    typedef enum logic [1:0] {
        SP_OP_NONE = 2'b00,
        SP_OP_INC  = 2'b01,
        SP_OP_DEC  = 2'b10,
        SP_OP_RSVD = 2'b11
    } sp_op_e;

    function automatic logic [63:0] reset_value(input int idx);
        case (idx)
            WR_ID:   return WR_RESET;
            SR_ID:   return SR_RESET;
            SP_ID:   return SP_RESET;
            PC_ID:   return PC_RESET;
            default: return GP_RESET;
        endcase
    endfunction

endpackage

// File: rtl/reflet_sp_unit.sv
// Combinational next-SP calculation for the register bank.
// Ports:
//   sp_q     in  WORDSIZE  current stack pointer
//   sp_op    in  2         00 none, 01 inc, 10 dec, 11 none
//   sp_step  in  4         step in bytes, zero-extended
//   wr_sp    in  1         explicit write to SP this retire (wins over the step)
//   wr_data  in  WORDSIZE  explicit write data
//   sp_d     out WORDSIZE  next SP value
// Arithmetic is modulo 2^WORDSIZE, so the stack pointer wraps silently.
module reflet_sp_unit
    import reflet_regbank_pkg::*;
#(
    parameter int WORDSIZE = 16
) (
    input  logic [WORDSIZE-1:0] sp_q,
    input  logic [1:0]          sp_op,
    input  logic [3:0]          sp_step,
    input  logic                wr_sp,
    input  logic [WORDSIZE-1:0] wr_data,
    output logic [WORDSIZE-1:0] sp_d
);

    logic [WORDSIZE-1:0] step_ext;

    assign step_ext = WORDSIZE'(sp_step);

    always_comb begin
        sp_d = sp_q;
        if (wr_sp) begin
            sp_d = wr_data;
        end else begin
            case (sp_op_e'(sp_op))
                SP_OP_INC: sp_d = sp_q + step_ext;
                SP_OP_DEC: sp_d = sp_q - step_ext;
                default:   sp_d = sp_q;
            endcase
        end
    end

endmodule

// File: rtl/reflet_regbank.sv
// Reflet register bank: NUM_REGS x WORDSIZE registers with special-register
// sequencing (PC auto-increment, SP stepping, interrupt vector load, sticky quit).
// Optional feature macro: REFLET_SHADOW_BANK_EN -- saves WR/SR on interrupt entry
// and restores them on int_ret; when undefined, in_isr is tied to 0 and int_ret
// has no effect.
// Ports:
//   clk, reset (synchronous, active-low)
//   enable                   0 freezes all state
//   cpu_update               instruction retire strobe
//   rd_idx / rd_data         RD_PORTS packed combinational read ports
//   wr_en, wr_idx, wr_data   register write request
//   sp_op, sp_step           stack pointer step request
//   int_take, int_vector     interrupt entry (loads PC only)
//   int_ret                  return from interrupt
//   quit_req                 quit instruction
//   wr_q, sr_q, pc_q, sp_q   direct special-register views
//   quit                     sticky halt flag
//   in_isr                   shadow context in use
module reflet_regbank
    import reflet_regbank_pkg::*;
#(
    parameter  int WORDSIZE = 16,
    parameter  int NUM_REGS = 16,
    parameter  int RD_PORTS = 2,
    localparam int IW       = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         cpu_update,
    input  logic [RD_PORTS*IW-1:0]       rd_idx,
    output logic [RD_PORTS*WORDSIZE-1:0] rd_data,
    input  logic                         wr_en,
    input  logic [IW-1:0]                wr_idx,
    input  logic [WORDSIZE-1:0]          wr_data,
    input  logic [1:0]                   sp_op,
    input  logic [3:0]                   sp_step,
    input  logic                         int_take,
    input  logic [WORDSIZE-1:0]          int_vector,
    input  logic                         int_ret,
    input  logic                         quit_req,
    output logic [WORDSIZE-1:0]          wr_q,
    output logic [WORDSIZE-1:0]          sr_q,
    output logic [WORDSIZE-1:0]          pc_q,
    output logic [WORDSIZE-1:0]          sp_q,
    output logic                         quit,
    output logic                         in_isr
);

    localparam logic [IW-1:0] WR_IDX = IW'(WR_ID);
    localparam logic [IW-1:0] SR_IDX = IW'(SR_ID);
    localparam logic [IW-1:0] SP_IDX = IW'(SP_ID);
    localparam logic [IW-1:0] PC_IDX = IW'(PC_ID);

    logic [WORDSIZE-1:0] regs_q [NUM_REGS];
    logic [WORDSIZE-1:0] regs_d [NUM_REGS];
    logic                quit_q;
    logic                quit_d;
    logic                retire;
    logic                wr_sp;
    logic [WORDSIZE-1:0] sp_d;
    logic [WORDSIZE-1:0] pc_inc;

`ifdef REFLET_SHADOW_BANK_EN
    logic                in_isr_q;
    logic                in_isr_d;
    logic [WORDSIZE-1:0] shadow_wr_q;
    logic [WORDSIZE-1:0] shadow_wr_d;
    logic [WORDSIZE-1:0] shadow_sr_q;
    logic [WORDSIZE-1:0] shadow_sr_d;
`else
    logic                unused_int_ret;
    assign unused_int_ret = int_ret;
`endif

    // Once quit is set, retire is blocked for good until reset.
    assign retire = enable & cpu_update & ~quit_q;
    assign wr_sp  = wr_en & (wr_idx == SP_IDX);
    assign pc_inc = regs_q[PC_IDX] + WORDSIZE'(1);

    reflet_sp_unit #(
        .WORDSIZE (WORDSIZE)
    ) u_sp_unit (
        .sp_q    (regs_q[SP_IDX]),
        .sp_op   (sp_op),
        .sp_step (sp_step),
        .wr_sp   (wr_sp),
        .wr_data (wr_data),
        .sp_d    (sp_d)
    );

    always_comb begin
        regs_d = regs_q;
        quit_d = quit_q;
`ifdef REFLET_SHADOW_BANK_EN
        in_isr_d    = in_isr_q;
        shadow_wr_d = shadow_wr_q;
        shadow_sr_d = shadow_sr_q;
`endif
        if (retire) begin
            if (int_take) begin
                regs_d[PC_IDX] = int_vector;
`ifdef REFLET_SHADOW_BANK_EN
                // Only the outermost interrupt captures context.
                if (!in_isr_q) begin
                    shadow_wr_d = regs_q[WR_IDX];
                    shadow_sr_d = regs_q[SR_IDX];
                    in_isr_d    = 1'b1;
                end
`endif
            end else if (quit_req) begin
                quit_d         = 1'b1;
                regs_d[PC_IDX] = pc_inc;
            end else begin
                if (wr_en) begin
                    regs_d[wr_idx] = wr_data;
                end
                // sp_d already carries the explicit-write override.
                regs_d[SP_IDX] = sp_d;
                if (!(wr_en && (wr_idx == PC_IDX))) begin
                    regs_d[PC_IDX] = pc_inc;
                end
`ifdef REFLET_SHADOW_BANK_EN
                // Context restore overrides any same-cycle write to WR/SR.
                if (int_ret && in_isr_q) begin
                    regs_d[WR_IDX] = shadow_wr_q;
                    regs_d[SR_IDX] = shadow_sr_q;
                    in_isr_d       = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= WORDSIZE'(reset_value(i));
            end
            quit_q <= 1'b0;
`ifdef REFLET_SHADOW_BANK_EN
            in_isr_q    <= 1'b0;
            shadow_wr_q <= '0;
            shadow_sr_q <= '0;
`endif
        end else begin
            regs_q <= regs_d;
            quit_q <= quit_d;
`ifdef REFLET_SHADOW_BANK_EN
            in_isr_q    <= in_isr_d;
            shadow_wr_q <= shadow_wr_d;
            shadow_sr_q <= shadow_sr_d;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd_port
            assign rd_data[gi*WORDSIZE +: WORDSIZE] = regs_q[rd_idx[gi*IW +: IW]];
        end
    endgenerate

    assign wr_q = regs_q[WR_IDX];
    assign sr_q = regs_q[SR_IDX];
    assign pc_q = regs_q[PC_IDX];
    assign sp_q = regs_q[SP_IDX];
    assign quit = quit_q;

`ifdef REFLET_SHADOW_BANK_EN
    assign in_isr = in_isr_q;
`else
    assign in_isr = 1'b0;
`endif

endmodule

// File: tb/tb_reflet_regbank.sv
// Self-checking bench for reflet_regbank (WORDSIZE=16, NUM_REGS=16, RD_PORTS=2).
// A behavioural model of the register file is updated on every rising edge and
// compared against every DUT output on each falling edge; directed steps add
// literal expectations.
module tb_reflet_regbank;
    import reflet_regbank_pkg::*;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int P  = 2;
    localparam int IW = 4;

    logic            clk        = 1'b0;
    logic            reset      = 1'b0;
    logic            enable     = 1'b0;
    logic            cpu_update = 1'b0;
    logic [P*IW-1:0] rd_idx     = '0;
    logic [P*W-1:0]  rd_data;
    logic            wr_en      = 1'b0;
    logic [IW-1:0]   wr_idx     = '0;
    logic [W-1:0]    wr_data    = '0;
    logic [1:0]      sp_op      = '0;
    logic [3:0]      sp_step    = '0;
    logic            int_take   = 1'b0;
    logic [W-1:0]    int_vector = '0;
    logic            int_ret    = 1'b0;
    logic            quit_req   = 1'b0;
    logic [W-1:0]    wr_q, sr_q, pc_q, sp_q;
    logic            quit, in_isr;

    reflet_regbank #(
        .WORDSIZE (W),
        .NUM_REGS (N),
        .RD_PORTS (P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cpu_update (cpu_update),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .sp_op      (sp_op),
        .sp_step    (sp_step),
        .int_take   (int_take),
        .int_vector (int_vector),
        .int_ret    (int_ret),
        .quit_req   (quit_req),
        .wr_q       (wr_q),
        .sr_q       (sr_q),
        .pc_q       (pc_q),
        .sp_q       (sp_q),
        .quit       (quit),
        .in_isr     (in_isr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    int unsigned m_regs [N];
    bit          m_quit;
    bit          m_isr;
    int unsigned m_sh_wr, m_sh_sr;

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Model: apply the retire rules in plain integer arithmetic.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = 32'(W'(reset_value(i)));
            m_quit  = 1'b0;
            m_isr   = 1'b0;
            m_sh_wr = 0;
            m_sh_sr = 0;
        end else if (enable && cpu_update && !m_quit) begin
            if (int_take) begin
`ifdef REFLET_SHADOW_BANK_EN
                if (!m_isr) begin
                    m_sh_wr = m_regs[WR_ID];
                    m_sh_sr = m_regs[SR_ID];
                    m_isr   = 1'b1;
                end
`endif
                m_regs[PC_ID] = int_vector;
            end else if (quit_req) begin
                m_quit        = 1'b1;
                m_regs[PC_ID] = (m_regs[PC_ID] + 1) % 65536;
            end else begin
                if (sp_op == 2'b01) m_regs[SP_ID] = (m_regs[SP_ID] + sp_step) % 65536;
                if (sp_op == 2'b10) m_regs[SP_ID] = (m_regs[SP_ID] + 65536 - sp_step) % 65536;
                m_regs[PC_ID] = (m_regs[PC_ID] + 1) % 65536;
                // An explicit write replaces whatever stepping produced.
                if (wr_en) m_regs[wr_idx] = wr_data;
`ifdef REFLET_SHADOW_BANK_EN
                if (int_ret && m_isr) begin
                    m_regs[WR_ID] = m_sh_wr;
                    m_regs[SR_ID] = m_sh_sr;
                    m_isr         = 1'b0;
                end
`endif
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp("pc",     pc_q, W'(m_regs[PC_ID]));
            cmp("sp",     sp_q, W'(m_regs[SP_ID]));
            cmp("wr",     wr_q, W'(m_regs[WR_ID]));
            cmp("sr",     sr_q, W'(m_regs[SR_ID]));
            cmp("quit",   W'(quit), W'(m_quit));
            cmp("in_isr", W'(in_isr), W'(m_isr));
            cmp("rd0",    rd_data[15:0],  W'(m_regs[rd_idx[3:0]]));
            cmp("rd1",    rd_data[31:16], W'(m_regs[rd_idx[7:4]]));
        end
    end

    task automatic cyc(input logic en, input logic upd, input logic we, input logic [3:0] widx,
                       input logic [15:0] wd, input logic [1:0] op, input logic [3:0] st,
                       input logic it, input logic [15:0] iv, input logic ir, input logic qr);
        enable = en; cpu_update = upd; wr_en = we; wr_idx = widx; wr_data = wd;
        sp_op = op; sp_step = st; int_take = it; int_vector = iv; int_ret = ir; quit_req = qr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        rd_idx = {4'(SP_ID), 4'd5};
        do_reset();
        check_en = 1'b1;

        // 1. Reset values and first write
        cmp("lit_reset_pc", pc_q, W'(PC_RESET));
        cmp("lit_reset_sp", sp_q, W'(SP_RESET));
        cmp("lit_reset_quit", W'(quit), 16'h0);
        cyc(1, 1, 1, 4'd5, 16'hBEEF, 0, 0, 0, 0, 0, 0);
        cmp("lit_rd5", rd_data[15:0], 16'hBEEF);
        cmp("lit_pc_inc", pc_q, W'(PC_RESET) + 16'h1);

        // 2. SP wrap in both directions
        cyc(1, 1, 1, 4'(SP_ID), 16'h0001, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 2'b10, 4'd2, 0, 0, 0, 0);
        cmp("lit_sp_wrap_dec", sp_q, 16'hFFFF);
        cyc(1, 1, 1, 4'(SP_ID), 16'hFFFE, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 2'b01, 4'd2, 0, 0, 0, 0);
        cmp("lit_sp_wrap_inc", sp_q, 16'h0000);

        // 3. Write conflicts
        cyc(1, 1, 1, 4'(SP_ID), 16'h1234, 2'b01, 4'd2, 0, 0, 0, 0);
        cmp("lit_sp_write_wins", sp_q, 16'h1234);
        cyc(1, 1, 1, 4'(PC_ID), 16'h0040, 0, 0, 0, 0, 0, 0);
        cmp("lit_pc_write_wins", pc_q, 16'h0040);

        // 4. Interrupt entry, and frozen cycles
        cyc(1, 1, 1, 4'(PC_ID), 16'h0010, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 4'd5, 16'h1111, 2'b01, 4'd4, 1, 16'h0200, 0, 0);
        cmp("lit_int_pc", pc_q, 16'h0200);
        cmp("lit_int_no_write", rd_data[15:0], 16'hBEEF);
        cyc(1, 0, 1, 4'd5, 16'h2222, 2'b01, 4'd4, 0, 0, 0, 0);
        cyc(0, 1, 1, 4'd5, 16'h3333, 2'b01, 4'd4, 1, 16'h0500, 0, 0);
        cmp("lit_frozen_pc", pc_q, 16'h0200);
        cmp("lit_frozen_rd5", rd_data[15:0], 16'hBEEF);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(255) != 0);
            rd_idx = P*IW'($urandom);
            cyc($urandom_range(9) != 0, $urandom_range(9) < 7, $urandom_range(9) < 4,
                4'($urandom), 16'($urandom), 2'($urandom), 4'($urandom),
                $urandom_range(15) == 0, 16'($urandom), $urandom_range(7) == 0,
                $urandom_range(127) == 0);
        end

        // 5. Quit is sticky; reset clears it
        rd_idx = {4'(SP_ID), 4'd5};
        do_reset();
        cyc(1, 1, 1, 4'(PC_ID), 16'h0030, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 4'd5, 16'h4444, 0, 0, 0, 0, 0, 1);
        cmp("lit_quit_set", W'(quit), 16'h1);
        cmp("lit_quit_pc", pc_q, 16'h0031);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 16'h0700, 0, 0);
        cyc(1, 1, 1, 4'd5, 16'h5555, 2'b01, 4'd3, 0, 0, 0, 0);
        cmp("lit_quit_hold_pc", pc_q, 16'h0031);
        cmp("lit_quit_hold_rd5", rd_data[15:0], W'(GP_RESET));
        reset = 1'b0;
        cyc(1, 1, 1, 4'd5, 16'h6666, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cmp("lit_rst_quit", W'(quit), 16'h0);
        cmp("lit_rst_pc", pc_q, W'(PC_RESET));

`ifdef REFLET_SHADOW_BANK_EN
        // 6. Shadow context save/restore with a nested interrupt
        cyc(1, 1, 1, 4'(WR_ID), 16'h00AA, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 4'(SR_ID), 16'h0081, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 16'h0100, 0, 0);
        cmp("lit_isr_enter", W'(in_isr), 16'h1);
        cyc(1, 1, 1, 4'(WR_ID), 16'h0055, 0, 0, 0, 0, 0, 0);
        cmp("lit_isr_wr", wr_q, 16'h0055);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 16'h0300, 0, 0);
        cmp("lit_nested_pc", pc_q, 16'h0300);
        cyc(1, 1, 1, 4'(WR_ID), 16'h7777, 0, 0, 0, 0, 1, 0);
        cmp("lit_ret_wr", wr_q, 16'h00AA);
        cmp("lit_ret_sr", sr_q, 16'h0081);
        cmp("lit_ret_isr", W'(in_isr), 16'h0);
        cmp("lit_ret_pc", pc_q, 16'h0301);
`else
        // int_ret without the shadow feature behaves as a plain retire
        cyc(1, 1, 1, 4'(WR_ID), 16'h00AA, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 4'(WR_ID), 16'h0055, 0, 0, 0, 0, 1, 0);
        cmp("lit_noshadow_wr", wr_q, 16'h0055);
        cmp("lit_noshadow_isr", W'(in_isr), 16'h0);
`endif

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
